// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI flash-side responder: oversamples the link on clk, decodes opcode/address and
// serves reads from, and posts writes to, a byte-wide memory port.
module mem_spi_flash_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DUMMY_CYC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_sclk,
  input  logic              in_cs_n,
  input  logic [3:0]        in_io,
  output logic [3:0]        out_io,
  output logic [3:0]        io_ena,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_rd_req,
  input  logic              in_rd_valid,
  input  logic [7:0]        in_rd_data,
  output logic              out_wr_valid,
  output logic [7:0]        out_wr_data,
  output logic              out_wel,
  output logic              out_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_QPP   = 8'h32;

  typedef enum logic [3:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_DUMMY, S_STATUS,
    S_READ_S, S_READ_Q, S_WRITE_S, S_WRITE_Q, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0]      sclk_sync_q, cs_sync_q;
  logic [SYNC_STAGES-1:0][3:0] io_sync_q;
  logic                        sclk_prev_q, cs_prev_q;
  logic                        sclk_s, cs_s;
  logic [3:0]                  io_s;
  logic                        rise, fall, cs_fall;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          sh_q, sh_d, opc_q, opc_d, data_q, data_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                buf_vld_q, buf_vld_d, rd_pend_q, rd_pend_d, wr_any_q, wr_any_d;
  logic [3:0]          out_io_q, out_io_d, io_ena_q, io_ena_d;
  logic                rd_req_q, rd_req_d, wr_valid_q, wr_valid_d, wel_q, wel_d, err_q, err_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          op_byte, wr_byte, tx_byte;
  logic                quad, last_bit, rd_hit;

  // CS_N synchronizer resets low so a CS held low across reset release is not seen as a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '0;
      io_sync_q   <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], in_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], in_cs_n};
      io_sync_q   <= {io_sync_q[SYNC_STAGES-2:0], in_io};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign io_s     = io_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign quad     = (state_q == S_READ_Q) || (state_q == S_WRITE_Q);
  assign last_bit = quad ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
  assign rd_hit   = rd_pend_q & in_rd_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    opc_d      = opc_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    buf_vld_d  = buf_vld_q;
    rd_pend_d  = rd_pend_q;
    wr_any_d   = wr_any_q;
    out_io_d   = out_io_q;
    io_ena_d   = io_ena_q;
    rd_req_d   = 1'b0;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    wel_d      = wel_q;
    err_d      = err_q;
    op_byte    = {sh_q[6:0], io_s[0]};
    wr_byte    = quad ? {sh_q[3:0], io_s} : {sh_q[6:0], io_s[0]};
    tx_byte    = data_q;

    if (rd_hit) begin
      data_d    = in_rd_data;
      buf_vld_d = 1'b1;
      rd_pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        io_ena_d  = 4'b0000;
        out_io_d  = 4'b0000;
        cnt_d     = '0;
        buf_vld_d = 1'b0;
        rd_pend_d = 1'b0;
        wr_any_d  = 1'b0;
        if (cs_fall) state_d = S_OPCODE;
      end
      S_OPCODE: if (rise) begin
        sh_d  = op_byte;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          cnt_d = '0;
          opc_d = op_byte;
          case (op_byte)
            OP_WREN: begin wel_d = 1'b1; state_d = S_IGNORE; end
            OP_RDSR: state_d = S_STATUS;
            OP_READ, OP_QREAD, OP_PP, OP_QPP: state_d = S_ADDR;
            default: state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR: if (rise) begin
        mem_addr_d = {mem_addr_q[ADDR_W-2:0], io_s[0]};
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(23)) begin
          cnt_d    = '0;
          wr_any_d = 1'b0;
          case (opc_q)
            OP_READ, OP_QREAD: begin
              state_d   = (opc_q == OP_READ) ? S_READ_S : S_DUMMY;
              rd_req_d  = 1'b1;
              rd_pend_d = 1'b1;
              buf_vld_d = 1'b0;
            end
            OP_PP:   state_d = S_WRITE_S;
            default: state_d = S_WRITE_Q;
          endcase
        end
      end
      S_DUMMY: if (rise) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_READ_Q;
        end
      end
      S_STATUS, S_READ_S, S_READ_Q: begin
        // First fall of a byte loads the shift buffer; an empty buffer is an underrun
        if (fall) begin
          io_ena_d = quad ? 4'b1111 : 4'b0010;
          if (cnt_q == '0) begin
            if (state_q == S_STATUS) tx_byte = {6'b0, wel_q, 1'b0};
            else if (buf_vld_q)      tx_byte = data_q;
            else if (rd_hit)         tx_byte = in_rd_data;
            else begin
              tx_byte = 8'hFF;
              err_d   = 1'b1;
            end
            buf_vld_d = 1'b0;
            rd_pend_d = 1'b0;
          end
          if (quad) begin
            out_io_d = tx_byte[7:4];
            data_d   = {tx_byte[3:0], 4'b0000};
          end else begin
            out_io_d = {2'b00, tx_byte[7], 1'b0};
            data_d   = {tx_byte[6:0], 1'b0};
          end
        end
        if (rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_bit) begin
            cnt_d = '0;
            if (state_q != S_STATUS) begin
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              rd_req_d   = 1'b1;
              rd_pend_d  = 1'b1;
              buf_vld_d  = 1'b0;
            end
          end
        end
      end
      S_WRITE_S, S_WRITE_Q: begin
        // Address advances the cycle after each strobe, wrapping inside the 256-byte page
        if (wr_valid_q) mem_addr_d = {mem_addr_q[ADDR_W-1:8], mem_addr_q[7:0] + 8'd1};
        if (rise) begin
          sh_d  = wr_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_bit) begin
            cnt_d    = '0;
            wr_any_d = 1'b1;
            if (wel_q) begin
              wr_valid_d = 1'b1;
              wr_data_d  = wr_byte;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_IGNORE: io_ena_d = 4'b0000;
      default:  state_d = S_IDLE;
    endcase

    // CS high aborts everything: partial bytes and outstanding read responses are dropped
    if (cs_s && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      io_ena_d   = 4'b0000;
      rd_req_d   = 1'b0;
      wr_valid_d = 1'b0;
      rd_pend_d  = 1'b0;
      buf_vld_d  = 1'b0;
      if (((state_q == S_WRITE_S) || (state_q == S_WRITE_Q)) && wr_any_q) wel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      opc_q      <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      buf_vld_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_any_q   <= 1'b0;
      out_io_q   <= '0;
      io_ena_q   <= '0;
      rd_req_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      opc_q      <= opc_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      buf_vld_q  <= buf_vld_d;
      rd_pend_q  <= rd_pend_d;
      wr_any_q   <= wr_any_d;
      out_io_q   <= out_io_d;
      io_ena_q   <= io_ena_d;
      rd_req_q   <= rd_req_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wel_q      <= wel_d;
      err_q      <= err_d;
    end
  end

  assign out_io       = out_io_q;
  assign io_ena       = io_ena_q;
  assign out_mem_addr = mem_addr_q;
  assign out_rd_req   = rd_req_q;
  assign out_wr_valid = wr_valid_q;
  assign out_wr_data  = wr_data_q;
  assign out_wel      = wel_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Directed bench for mem_spi_flash_responder: a behavioural SPI controller plus a byte memory,
// with write strobes and read requests checked against expectation queues.
module tb_mem_spi_flash_responder;

  localparam int HP = 5;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_sclk = 1'b1;
  logic        in_cs_n = 1'b1;
  logic [3:0]  in_io = 4'h0;
  logic [3:0]  out_io, io_ena;
  logic [23:0] out_mem_addr;
  logic        out_rd_req, out_wr_valid, out_wel, out_err;
  logic        in_rd_valid = 1'b0;
  logic [7:0]  in_rd_data = 8'h00;
  logic [7:0]  out_wr_data;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  bit          hold_rd = 1'b0;
  logic [7:0]  mem [0:511];
  wr_t         wr_q[$];
  logic [23:0] rd_q[$];

  mem_spi_flash_responder #(.ADDR_W(24), .SYNC_STAGES(2), .DUMMY_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_sclk(in_sclk), .in_cs_n(in_cs_n), .in_io(in_io),
    .out_io(out_io), .io_ena(io_ena), .out_mem_addr(out_mem_addr), .out_rd_req(out_rd_req),
    .in_rd_valid(in_rd_valid), .in_rd_data(in_rd_data), .out_wr_valid(out_wr_valid),
    .out_wr_data(out_wr_data), .out_wel(out_wel), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard
  always @(negedge clk) begin
    if (rst_n && out_wr_valid) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(out_wr_valid), 32'h0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(out_mem_addr), 32'(e.addr));
        check("wr_data", 32'(out_wr_data), 32'(e.data));
      end
    end
  end

  // Memory model: answers each request one cycle later unless withheld
  always @(negedge clk) begin
    in_rd_valid = 1'b0;
    if (rst_n && out_rd_req) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'(out_rd_req), 32'h0);
      else check("rd_req_addr", 32'(out_mem_addr), 32'(rd_q.pop_front()));
      if (!hold_rd) begin
        in_rd_valid = 1'b1;
        in_rd_data  = mem[out_mem_addr[8:0]];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic sclk_cycle(input logic [3:0] drv, output logic [3:0] smp, output logic [3:0] ena);
    in_sclk = 1'b0;
    in_io   = drv;
    tick(HP);
    smp     = out_io;
    ena     = io_ena;
    in_sclk = 1'b1;
    tick(HP);
  endtask

  task automatic cs_start();
    in_cs_n = 1'b0;
    tick(HP);
  endtask

  task automatic cs_end();
    in_cs_n = 1'b1;
    tick(2 * HP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] s, e;
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, b[i]}, s, e);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic send_qbyte(input logic [7:0] b);
    logic [3:0] s, e;
    sclk_cycle(b[7:4], s, e);
    sclk_cycle(b[3:0], s, e);
  endtask

  task automatic recv_single(output logic [7:0] b, output logic [3:0] ena);
    logic [3:0] s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(4'h0, s, ena);
      b = {b[6:0], s[1]};
    end
  endtask

  task automatic recv_quad(output logic [7:0] b, output logic [3:0] ena);
    logic [3:0] hi, lo;
    sclk_cycle(4'h0, hi, ena);
    sclk_cycle(4'h0, lo, ena);
    b = {hi, lo};
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] e, s, e_or;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[9'h0FF] = 8'h11;
    mem[9'h100] = 8'h22;
    mem[9'h040] = 8'hC3;

    do_reset();
    check("rst_out_io", 32'(out_io), 32'h0);
    check("rst_io_ena", 32'(io_ena), 32'h0);
    check("rst_addr", 32'(out_mem_addr), 32'h0);
    check("rst_rd_req", 32'(out_rd_req), 32'h0);
    check("rst_wr_valid", 32'(out_wr_valid), 32'h0);
    check("rst_wr_data", 32'(out_wr_data), 32'h0);
    check("rst_wel", 32'(out_wel), 32'h0);
    check("rst_err", 32'(out_err), 32'h0);

    // WREN then PP
    cs_start(); send_byte(8'h06); cs_end();
    check("wren_wel", 32'(out_wel), 32'h1);
    wr_q.push_back('{addr: 24'h000010, data: 8'hA5});
    wr_q.push_back('{addr: 24'h000011, data: 8'h3C});
    cs_start(); send_byte(8'h02); send_addr(24'h000010);
    send_byte(8'hA5); send_byte(8'h3C); cs_end();
    check("pp_wr_left", 32'(wr_q.size()), 32'h0);
    check("pp_wel_clr", 32'(out_wel), 32'h0);
    check("pp_err", 32'(out_err), 32'h0);

    // Single read crossing 0xFF -> 0x100
    rd_q.push_back(24'h0000FF); rd_q.push_back(24'h000100); rd_q.push_back(24'h000101);
    cs_start(); send_byte(8'h03); send_addr(24'h0000FF);
    recv_single(b, e);
    check("read_b0", 32'(b), 32'h11);
    check("read_ena", 32'(e), 32'h2);
    recv_single(b, e);
    check("read_b1", 32'(b), 32'h22);
    cs_end();
    check("read_rq_left", 32'(rd_q.size()), 32'h0);
    check("read_ena_idle", 32'(io_ena), 32'h0);

    // Quad read with dummy cycles
    rd_q.push_back(24'h000040); rd_q.push_back(24'h000041);
    cs_start(); send_byte(8'h6B); send_addr(24'h000040);
    e_or = 4'h0;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(4'h0, s, e);
      e_or = e_or | e;
    end
    check("qread_dummy_ena", 32'(e_or), 32'h0);
    sclk_cycle(4'h0, s, e);
    check("qread_hi", 32'(s), 32'hC);
    check("qread_ena", 32'(e), 32'hF);
    sclk_cycle(4'h0, s, e);
    check("qread_lo", 32'(s), 32'h3);
    cs_end();
    check("qread_rq_left", 32'(rd_q.size()), 32'h0);

    // QPP with page wrap
    cs_start(); send_byte(8'h06); cs_end();
    wr_q.push_back('{addr: 24'h0000FE, data: 8'h01});
    wr_q.push_back('{addr: 24'h0000FF, data: 8'h02});
    wr_q.push_back('{addr: 24'h000000, data: 8'h03});
    cs_start(); send_byte(8'h32); send_addr(24'h0000FE);
    send_qbyte(8'h01); send_qbyte(8'h02); send_qbyte(8'h03); cs_end();
    check("qpp_wr_left", 32'(wr_q.size()), 32'h0);
    check("qpp_wel_clr", 32'(out_wel), 32'h0);

    // RDSR after WREN, two repeats
    cs_start(); send_byte(8'h06); cs_end();
    cs_start(); send_byte(8'h05);
    recv_single(b, e);
    check("rdsr_b0", 32'(b), 32'h02);
    check("rdsr_ena", 32'(e), 32'h2);
    recv_single(b, e);
    check("rdsr_b1", 32'(b), 32'h02);
    cs_end();

    // Partial PP byte is discarded and WEL survives
    cs_start(); send_byte(8'h02); send_addr(24'h000080);
    for (int i = 0; i < 4; i++) sclk_cycle(4'h1, s, e);
    cs_end();
    check("partial_wel", 32'(out_wel), 32'h1);
    check("partial_ena", 32'(io_ena), 32'h0);
    check("partial_err", 32'(out_err), 32'h0);

    // Unknown opcode is ignored
    cs_start(); send_byte(8'h9F);
    e_or = 4'h0;
    for (int i = 0; i < 16; i++) begin
      sclk_cycle(4'h0, s, e);
      e_or = e_or | e;
    end
    cs_end();
    check("ignore_ena", 32'(e_or), 32'h0);

    // PP without WREN
    do_reset();
    check("rst2_wel", 32'(out_wel), 32'h0);
    cs_start(); send_byte(8'h02); send_addr(24'h000030); send_byte(8'h55); cs_end();
    check("nowren_err", 32'(out_err), 32'h1);

    // Read underrun
    do_reset();
    check("rst3_err", 32'(out_err), 32'h0);
    hold_rd = 1'b1;
    rd_q.push_back(24'h000020); rd_q.push_back(24'h000021);
    cs_start(); send_byte(8'h03); send_addr(24'h000020);
    recv_single(b, e);
    check("underrun_byte", 32'(b), 32'hFF);
    cs_end();
    check("underrun_err", 32'(out_err), 32'h1);
    check("underrun_rq_left", 32'(rd_q.size()), 32'h0);
    hold_rd = 1'b0;

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
